// File: rtl/hazard_sequencer.sv
// hazard_sequencer: branch resolve, load-use detect, dmem wait FSM,
// prioritised pipeline hold/flush/bubble controls and stall/flush stats.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   id_rs1/rs2, id_uses_ID source regs and read enables
//   ex_rd, ex_mem_read   EX destination and load flag
//   ex_branch/funct3/op  EX branch type and forwarded operands
//   mem_req, dmem_ready  MEM access pending / completing
//   pc_hold..memwb_bubble, pc_sel_branch  pipeline controls
//   err_timeout          sticky dmem timeout flag
//   stall_cycles, flush_count  saturating statistics
module hazard_sequencer #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_op_a,
  input  logic [XLEN-1:0]  ex_op_b,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic             pc_sel_branch,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WC_W-1:0]   r_wait_cnt;
  logic [WC_W-1:0]   w_wait_nxt;
  logic              r_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_cond;
  logic w_taken;
  logic w_load_use;
  logic w_mem_busy;
  logic w_lt_s;
  logic w_lt_u;
  logic w_eq;

  assign w_eq   = (ex_op_a == ex_op_b);
  assign w_lt_s = ($signed(ex_op_a) < $signed(ex_op_b));
  assign w_lt_u = (ex_op_a < ex_op_b);

  always_comb begin
    w_cond = 1'b0;
    case (ex_funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = ~w_eq;
      3'b100:  w_cond = w_lt_s;
      3'b101:  w_cond = ~w_lt_s;
      3'b110:  w_cond = w_lt_u;
      3'b111:  w_cond = ~w_lt_u;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken    = ex_branch & w_cond;
  assign w_mem_busy = mem_req & ~dmem_ready;
  assign w_load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      S_RUN: begin
        if (w_mem_busy) begin
          w_state_nxt = S_WAIT;
          w_wait_nxt  = WC_W'(1);
        end
      end
      S_WAIT: begin
        if (!w_mem_busy) begin
          w_state_nxt = S_RUN;
          w_wait_nxt  = '0;
        end else if (r_wait_cnt == WC_LAST) begin
          w_state_nxt = S_ERR;
        end else begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: begin
        w_state_nxt = S_RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // A memory stall freezes EX/ID, so branch and load-use are
  // naturally re-evaluated once the access completes.
  always_comb begin
    pc_hold       = 1'b0;
    ifid_hold     = 1'b0;
    ifid_flush    = 1'b0;
    idex_hold     = 1'b0;
    idex_flush    = 1'b0;
    exmem_hold    = 1'b0;
    memwb_bubble  = 1'b0;
    pc_sel_branch = 1'b0;
    if ((r_state == S_ERR) || w_mem_busy) begin
      pc_hold      = 1'b1;
      ifid_hold    = 1'b1;
      idex_hold    = 1'b1;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (w_taken) begin
      pc_sel_branch = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
    end else if (w_load_use) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_state_nxt == S_ERR)
        r_err <= 1'b1;
      if (pc_hold && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (pc_sel_branch && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign err_timeout  = r_err;
  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule
